// File: rtl/patch_row_dispatcher_pkg.sv
// Shared definitions for the patch-row dispatcher: FP zero, log2 helper and
// the PATCH_SIZE / FP_SIZE defaults shared with the reducer bank.
package patch_row_dispatcher_pkg;

  localparam int unsigned DEF_PATCH_SIZE = 16;
  localparam int unsigned DEF_FP_SIZE    = 32;
  localparam logic [31:0] FP_ZERO        = 32'h0000_0000;

  // Ceiling log2; log2_ceil(1) is 0.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/patch_row_dispatcher_if.sv
// Job (cfg_*) and result (sum_*) handshake bundle of the patch-row dispatcher.
interface patch_row_dispatcher_if #(
  parameter int unsigned PN         = 10,
  parameter int unsigned ROW_W      = 11,
  parameter int unsigned COL_W      = 11,
  parameter int unsigned FP_W       = 32,
  parameter int unsigned PATCH_SIZE = 16
) ();

  logic                       cfg_valid;
  logic                       cfg_ack;
  logic [PN-1:0]              cfg_patch_num;
  logic [ROW_W-1:0]           cfg_row;
  logic [COL_W-1:0]           cfg_col;
  logic [FP_W-1:0]            cfg_sum;
  logic [PATCH_SIZE*FP_W-1:0] cfg_weights;

  logic                       sum_valid;
  logic                       sum_ack;
  logic [FP_W-1:0]            sum_out;
  logic [PN-1:0]              sum_patch_num;

  // Job source / result consumer side
  modport master (
    output cfg_valid, cfg_patch_num, cfg_row, cfg_col, cfg_sum, cfg_weights,
    input  cfg_ack,
    input  sum_valid, sum_out, sum_patch_num,
    output sum_ack
  );

  // Dispatcher side
  modport slave (
    input  cfg_valid, cfg_patch_num, cfg_row, cfg_col, cfg_sum, cfg_weights,
    output cfg_ack,
    output sum_valid, sum_out, sum_patch_num,
    input  sum_ack
  );

endinterface

// File: rtl/patch_row_dispatcher_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module patch_row_dispatcher_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  // Rotating priority search starting at ptr
  always_comb begin
    int unsigned   j;
    logic [IW-1:0] cand;
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    j       = 0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!any_c && req[cand]) begin
        any_c         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = cand;
      end
    end
  end

endmodule

// File: rtl/patch_row_dispatcher.sv
// Issues patch-row jobs to free reducers and drains their results to one port.
// Optional build macro: PATCH_ROW_DISPATCHER_WATCHDOG_EN (per-reducer done timeout).
module patch_row_dispatcher
  import patch_row_dispatcher_pkg::*;
#(
  parameter int unsigned N_REDUCER       = 4,
  parameter int unsigned N_PATCH         = 1024,
  parameter int unsigned PATCH_SIZE      = DEF_PATCH_SIZE,
  parameter int unsigned N_COL_SIZE      = 11,
  parameter int unsigned N_ROW_SIZE      = 11,
  parameter int unsigned FP_SIZE         = DEF_FP_SIZE,
  parameter int unsigned WATCHDOG_CYCLES = 4096,
  localparam int unsigned PN = log2_ceil(N_PATCH),
  localparam int unsigned IW = log2_ceil(N_REDUCER),
  localparam int unsigned OW = IW + 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  patch_row_dispatcher_if.slave         host,
  output logic [N_REDUCER-1:0]          init,
  output logic [PN-1:0]                 conf_patch_num,
  output logic [N_ROW_SIZE-1:0]         conf_row,
  output logic [N_COL_SIZE-1:0]         conf_col,
  output logic [FP_SIZE-1:0]            conf_sum,
  output logic [PATCH_SIZE*FP_SIZE-1:0] conf_weights,
  input  logic [N_REDUCER-1:0]          reducer_available,
  input  logic [N_REDUCER-1:0]          reducer_done,
  input  logic [N_REDUCER*FP_SIZE-1:0]  reducer_sum,
  input  logic [N_REDUCER*PN-1:0]       reducer_patch_num,
  output logic [OW-1:0]                 outstanding,
  output logic [N_REDUCER-1:0]          wd_err
);

  if (N_REDUCER < 2 || WATCHDOG_CYCLES < 2) begin : g_param_check
    $error("patch_row_dispatcher: N_REDUCER and WATCHDOG_CYCLES must be >= 2");
  end

  logic [N_REDUCER-1:0] pending, eligible, wd_block, wd_hit;
  logic [N_REDUCER-1:0] iss_grant, drn_grant;
  logic [IW-1:0]        iss_ptr, drn_ptr, iss_idx, drn_idx;
  logic                 iss_any, drn_any, issue, drain_load, out_hs;
  logic [FP_SIZE-1:0]   slot_sum [N_REDUCER];
  logic [PN-1:0]        slot_pn  [N_REDUCER];
  logic [FP_SIZE-1:0]   done_sum [N_REDUCER];
  logic [PN-1:0]        done_pn  [N_REDUCER];

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (32'(i) == N_REDUCER - 1) ? '0 : IW'(i + 1'b1);
  endfunction

  // Slice the packed reducer result buses per reducer
  for (genvar g = 0; g < N_REDUCER; g++) begin : g_unpack
    assign done_sum[g] = reducer_sum[g*FP_SIZE +: FP_SIZE];
    assign done_pn[g]  = reducer_patch_num[g*PN +: PN];
  end

  // init masks the cycle in which a just-issued reducer still reports available
  assign eligible     = reducer_available & ~init & ~pending & ~wd_block;
  assign issue        = host.cfg_valid & iss_any;
  assign host.cfg_ack = issue;
  assign drain_load   = ~host.sum_valid | host.sum_ack;
  assign out_hs       = host.sum_valid & host.sum_ack;

  patch_row_dispatcher_rr_arbiter #(.N(N_REDUCER), .IW(IW)) u_issue_arb (
    .req(eligible), .ptr(iss_ptr), .grant_c(iss_grant), .idx_c(iss_idx), .any_c(iss_any)
  );

  patch_row_dispatcher_rr_arbiter #(.N(N_REDUCER), .IW(IW)) u_drain_arb (
    .req(pending), .ptr(drn_ptr), .grant_c(drn_grant), .idx_c(drn_idx), .any_c(drn_any)
  );

  // Job issue: one-cycle init pulse plus shared conf_* bus load
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      init           <= '0;
      conf_patch_num <= '0;
      conf_row       <= '0;
      conf_col       <= '0;
      conf_sum       <= FP_SIZE'(FP_ZERO);
      conf_weights   <= '0;
      iss_ptr        <= '0;
    end else begin
      init <= '0;
      if (issue) begin
        init           <= iss_grant;
        conf_patch_num <= host.cfg_patch_num;
        conf_row       <= host.cfg_row;
        conf_col       <= host.cfg_col;
        conf_sum       <= host.cfg_sum;
        conf_weights   <= host.cfg_weights;
        iss_ptr        <= next_ptr(iss_idx);
      end
    end
  end

  // Result capture into per-reducer slots and drain to the output register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending            <= '0;
      drn_ptr            <= '0;
      host.sum_valid     <= 1'b0;
      host.sum_out       <= FP_SIZE'(FP_ZERO);
      host.sum_patch_num <= '0;
      wd_err             <= '0;
      for (int unsigned i = 0; i < N_REDUCER; i++) begin
        slot_sum[i] <= FP_SIZE'(FP_ZERO);
        slot_pn[i]  <= '0;
      end
    end else begin
      pending <= (pending & ~(drain_load ? drn_grant : '0)) | reducer_done;
      wd_err  <= wd_err | wd_hit | (reducer_done & pending);
      if (drain_load) begin
        host.sum_valid <= drn_any;
        if (drn_any) begin
          host.sum_out       <= slot_sum[drn_idx];
          host.sum_patch_num <= slot_pn[drn_idx];
          drn_ptr            <= next_ptr(drn_idx);
        end
      end
      for (int unsigned i = 0; i < N_REDUCER; i++) begin
        if (reducer_done[i]) begin
          slot_sum[i] <= done_sum[i];
          slot_pn[i]  <= done_pn[i];
        end
      end
    end
  end

  // Jobs issued but not yet drained
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      outstanding <= '0;
    end else begin
      case ({issue, out_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef PATCH_ROW_DISPATCHER_WATCHDOG_EN
  localparam int unsigned WW = log2_ceil(WATCHDOG_CYCLES) + 1;

  logic [WW-1:0]        wd_cnt [N_REDUCER];
  logic [N_REDUCER-1:0] wd_run, wd_to;

  // Timeout when a running counter reaches WATCHDOG_CYCLES without a done
  always_comb begin
    wd_hit = '0;
    for (int unsigned i = 0; i < N_REDUCER; i++) begin
      wd_hit[i] = wd_run[i] & ~init[i] & ~reducer_done[i] &
                  (wd_cnt[i] == WW'(WATCHDOG_CYCLES - 1));
    end
  end

  // Per-reducer done counters, started by init and stopped by done or timeout
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_run <= '0;
      wd_to  <= '0;
      for (int unsigned i = 0; i < N_REDUCER; i++) wd_cnt[i] <= '0;
    end else begin
      wd_to <= wd_to | wd_hit;
      for (int unsigned i = 0; i < N_REDUCER; i++) begin
        if (init[i]) begin
          wd_run[i] <= 1'b1;
          wd_cnt[i] <= WW'(1);
        end else if (reducer_done[i] || wd_hit[i]) begin
          wd_run[i] <= 1'b0;
        end else if (wd_run[i]) begin
          wd_cnt[i] <= wd_cnt[i] + WW'(1);
        end
      end
    end
  end

  assign wd_block = wd_to;
`else
  assign wd_hit   = '0;
  assign wd_block = '0;
`endif

endmodule

// File: tb/tb_patch_row_dispatcher.sv
// Directed self-checking bench for patch_row_dispatcher (4 reducers).
module tb_patch_row_dispatcher;

  localparam int unsigned N  = 4;
  localparam int unsigned PN = 10;
  localparam int unsigned RW = 11;
  localparam int unsigned CW = 11;
  localparam int unsigned FW = 32;
  localparam int unsigned PS = 16;

  logic              CLK;
  logic              RESET;
  logic [N-1:0]      init;
  logic [PN-1:0]     conf_patch_num;
  logic [RW-1:0]     conf_row;
  logic [CW-1:0]     conf_col;
  logic [FW-1:0]     conf_sum;
  logic [PS*FW-1:0]  conf_weights;
  logic [N-1:0]      reducer_available;
  logic [N-1:0]      reducer_done;
  logic [N*FW-1:0]   reducer_sum;
  logic [N*PN-1:0]   reducer_patch_num;
  logic [2:0]        outstanding;
  logic [N-1:0]      wd_err;

  int checks = 0;
  int errors = 0;

  patch_row_dispatcher_if #(.PN(PN), .ROW_W(RW), .COL_W(CW), .FP_W(FW), .PATCH_SIZE(PS)) host_if ();

  patch_row_dispatcher #(
    .N_REDUCER(N), .N_PATCH(1024), .PATCH_SIZE(PS), .N_COL_SIZE(CW),
    .N_ROW_SIZE(RW), .FP_SIZE(FW), .WATCHDOG_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .host(host_if),
    .init(init), .conf_patch_num(conf_patch_num), .conf_row(conf_row),
    .conf_col(conf_col), .conf_sum(conf_sum), .conf_weights(conf_weights),
    .reducer_available(reducer_available), .reducer_done(reducer_done),
    .reducer_sum(reducer_sum), .reducer_patch_num(reducer_patch_num),
    .outstanding(outstanding), .wd_err(wd_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    host_if.cfg_valid     = 1'b0;
    host_if.cfg_patch_num = '0;
    host_if.cfg_row       = '0;
    host_if.cfg_col       = '0;
    host_if.cfg_sum       = '0;
    host_if.cfg_weights   = '0;
    host_if.sum_ack       = 1'b0;
    reducer_available     = '0;
    reducer_done          = '0;
    reducer_sum           = '0;
    reducer_patch_num     = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_inputs();
    tick();
    RESET = 1'b0;
  endtask

  task automatic set_result(input int idx, input logic [FW-1:0] s, input logic [PN-1:0] p);
    reducer_done[idx] = 1'b1;
    reducer_sum[idx*FW +: FW] = s;
    reducer_patch_num[idx*PN +: PN] = p;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (init !== 4'b0000) begin errors++; $display("FAIL rst_init got %b want 0000", init); end
    checks++; if (host_if.sum_valid !== 1'b0) begin errors++; $display("FAIL rst_sum_valid got %b want 0", host_if.sum_valid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
    checks++; if (wd_err !== 4'b0000) begin errors++; $display("FAIL rst_wd_err got %b want 0000", wd_err); end
    checks++; if (conf_patch_num !== 10'd0 || conf_sum !== 32'd0) begin errors++; $display("FAIL rst_conf got pn=%0d sum=%h want 0/0", conf_patch_num, conf_sum); end
    checks++; if (host_if.sum_out !== 32'd0 || host_if.sum_patch_num !== 10'd0) begin errors++; $display("FAIL rst_sum_out got %h/%0d want 0/0", host_if.sum_out, host_if.sum_patch_num); end
    reducer_available = 4'b1111;
    host_if.cfg_valid = 1'b1;
    #1;
    checks++; if (host_if.cfg_ack !== 1'b1) begin errors++; $display("FAIL rst_cfg_ack_comb got %b want 1", host_if.cfg_ack); end
    clear_inputs();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single_issue();
    do_reset();
    reducer_available     = 4'b1111;
    host_if.cfg_valid     = 1'b1;
    host_if.cfg_patch_num = 10'd5;
    host_if.cfg_row       = 11'd3;
    host_if.cfg_col       = 11'd4;
    host_if.cfg_sum       = 32'h4000_0000;
    host_if.cfg_weights   = {PS{32'h3F00_0000}};
    #1;
    checks++; if (host_if.cfg_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b want 1", host_if.cfg_ack); end
    tick();
    checks++; if (init !== 4'b0001) begin errors++; $display("FAIL single_init got %b want 0001", init); end
    checks++; if (conf_patch_num !== 10'd5 || conf_row !== 11'd3 || conf_col !== 11'd4 || conf_sum !== 32'h4000_0000)
      begin errors++; $display("FAIL single_conf got pn=%0d row=%0d col=%0d sum=%h want 5/3/4/40000000", conf_patch_num, conf_row, conf_col, conf_sum); end
    checks++; if (conf_weights !== {PS{32'h3F00_0000}}) begin errors++; $display("FAIL single_weights got %h", conf_weights[31:0]); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding got %0d want 1", outstanding); end
    host_if.cfg_valid = 1'b0;
    reducer_available = 4'b1110;
    tick();
    checks++; if (init !== 4'b0000) begin errors++; $display("FAIL single_init_drop got %b want 0000", init); end
    checks++; if (conf_patch_num !== 10'd5) begin errors++; $display("FAIL single_conf_hold got %0d want 5", conf_patch_num); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_init;
    do_reset();
    reducer_available     = 4'b1111;
    host_if.cfg_valid     = 1'b1;
    host_if.cfg_patch_num = 10'd10;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_init = 4'b0001 << k;
      checks++; if (init !== exp_init || conf_patch_num !== 10'(10 + k))
        begin errors++; $display("FAIL b2b_init%0d got %b/%0d want %b/%0d", k, init, conf_patch_num, exp_init, 10 + k); end
      reducer_available[k] = 1'b0;
      host_if.cfg_patch_num = 10'(11 + k);
    end
    #1;
    checks++; if (host_if.cfg_ack !== 1'b0) begin errors++; $display("FAIL b2b_fifth_blocked got %b want 0", host_if.cfg_ack); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL b2b_outstanding4 got %0d want 4", outstanding); end
    tick();
    checks++; if (init !== 4'b0000 || conf_patch_num !== 10'd13) begin errors++; $display("FAIL b2b_idle got %b/%0d want 0000/13", init, conf_patch_num); end
    // reducer 2 returns a result; its job slot frees only once drained
    set_result(2, 32'h3F80_0000, 10'd7);
    #1;
    checks++; if (host_if.cfg_ack !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_ack got %b want 0", host_if.cfg_ack); end
    tick();
    reducer_done = '0;
    reducer_available[2] = 1'b1;
    #1;
    checks++; if (host_if.sum_valid !== 1'b0 || host_if.cfg_ack !== 1'b0)
      begin errors++; $display("FAIL b2b_pending_cycle got valid=%b ack=%b want 0/0", host_if.sum_valid, host_if.cfg_ack); end
    tick();
    checks++; if (host_if.sum_valid !== 1'b1 || host_if.sum_out !== 32'h3F80_0000 || host_if.sum_patch_num !== 10'd7)
      begin errors++; $display("FAIL b2b_result got v=%b %h/%0d want 1 3f800000/7", host_if.sum_valid, host_if.sum_out, host_if.sum_patch_num); end
    checks++; if (host_if.cfg_ack !== 1'b1) begin errors++; $display("FAIL b2b_fifth_ack got %b want 1", host_if.cfg_ack); end
    tick();
    checks++; if (init !== 4'b0100 || conf_patch_num !== 10'd14) begin errors++; $display("FAIL b2b_fifth_init got %b/%0d want 0100/14", init, conf_patch_num); end
    checks++; if (host_if.sum_valid !== 1'b1 || host_if.sum_out !== 32'h3F80_0000) begin errors++; $display("FAIL b2b_hold got v=%b %h want 1 3f800000", host_if.sum_valid, host_if.sum_out); end
    checks++; if (outstanding !== 3'd5) begin errors++; $display("FAIL b2b_outstanding5 got %0d want 5", outstanding); end
    host_if.cfg_valid = 1'b0;
    reducer_available[2] = 1'b0;
    host_if.sum_ack = 1'b1;
    tick();
    checks++; if (host_if.sum_valid !== 1'b0 || outstanding !== 3'd4)
      begin errors++; $display("FAIL b2b_drained got v=%b out=%0d want 0/4", host_if.sum_valid, outstanding); end
    host_if.sum_ack = 1'b0;
  endtask

  task automatic test_dual_done();
    do_reset();
    reducer_available     = 4'b1111;
    host_if.cfg_valid     = 1'b1;
    host_if.cfg_patch_num = 10'd20;
    for (int k = 0; k < 4; k++) begin
      tick();
      reducer_available[k] = 1'b0;
      host_if.cfg_patch_num = 10'(21 + k);
    end
    host_if.cfg_valid = 1'b0;
    host_if.sum_ack   = 1'b1;
    set_result(1, 32'h4049_0FDB, 10'd21);
    set_result(3, 32'hC000_0000, 10'd23);
    tick();
    reducer_done = '0;
    checks++; if (host_if.sum_valid !== 1'b0) begin errors++; $display("FAIL dual_early got %b want 0", host_if.sum_valid); end
    tick();
    checks++; if (host_if.sum_valid !== 1'b1 || host_if.sum_out !== 32'h4049_0FDB || host_if.sum_patch_num !== 10'd21 || outstanding !== 3'd4)
      begin errors++; $display("FAIL dual_first got v=%b %h/%0d out=%0d want 1 40490fdb/21 4", host_if.sum_valid, host_if.sum_out, host_if.sum_patch_num, outstanding); end
    tick();
    checks++; if (host_if.sum_valid !== 1'b1 || host_if.sum_out !== 32'hC000_0000 || host_if.sum_patch_num !== 10'd23 || outstanding !== 3'd3)
      begin errors++; $display("FAIL dual_second got v=%b %h/%0d out=%0d want 1 c0000000/23 3", host_if.sum_valid, host_if.sum_out, host_if.sum_patch_num, outstanding); end
    tick();
    checks++; if (host_if.sum_valid !== 1'b0 || outstanding !== 3'd2)
      begin errors++; $display("FAIL dual_empty got v=%b out=%0d want 0/2", host_if.sum_valid, outstanding); end
    host_if.sum_ack = 1'b0;
  endtask

  task automatic test_double_done();
    do_reset();
    set_result(0, 32'h0101_0101, 10'd30);
    tick();
    reducer_done = '0;
    tick();
    checks++; if (host_if.sum_valid !== 1'b1 || host_if.sum_out !== 32'h0101_0101)
      begin errors++; $display("FAIL dbl_first got v=%b %h want 1 01010101", host_if.sum_valid, host_if.sum_out); end
    set_result(0, 32'h0202_0202, 10'd31);
    tick();
    checks++; if (wd_err !== 4'b0000) begin errors++; $display("FAIL dbl_no_err_yet got %b want 0000", wd_err); end
    set_result(0, 32'h0303_0303, 10'd32);
    tick();
    reducer_done = '0;
    checks++; if (wd_err !== 4'b0001 || host_if.sum_out !== 32'h0101_0101)
      begin errors++; $display("FAIL dbl_err got wd=%b sum=%h want 0001 01010101", wd_err, host_if.sum_out); end
    host_if.sum_ack = 1'b1;
    tick();
    checks++; if (host_if.sum_out !== 32'h0303_0303 || host_if.sum_patch_num !== 10'd32)
      begin errors++; $display("FAIL dbl_overwrite got %h/%0d want 03030303/32", host_if.sum_out, host_if.sum_patch_num); end
    host_if.sum_ack = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    reducer_available     = 4'b1111;
    host_if.cfg_valid     = 1'b1;
    host_if.cfg_patch_num = 10'd40;
    tick();
    reducer_available     = 4'b1110;
    host_if.cfg_patch_num = 10'd41;
    tick();
    reducer_available = 4'b1100;
    host_if.cfg_valid = 1'b0;
    set_result(0, 32'h1111_1111, 10'd40);
    set_result(1, 32'h2222_2222, 10'd41);
    tick();
    reducer_done = '0;
    tick();
    reducer_available     = 4'b0100;
    host_if.cfg_valid     = 1'b1;
    host_if.cfg_patch_num = 10'd42;
    tick();
    checks++; if (init !== 4'b0100 || host_if.sum_valid !== 1'b1 || outstanding !== 3'd3)
      begin errors++; $display("FAIL midrst_pre got init=%b v=%b out=%0d want 0100/1/3", init, host_if.sum_valid, outstanding); end
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (init !== 4'b0000 || host_if.sum_valid !== 1'b0 || outstanding !== 3'd0)
      begin errors++; $display("FAIL midrst_async got init=%b v=%b out=%0d want 0000/0/0", init, host_if.sum_valid, outstanding); end
    host_if.cfg_valid = 1'b0;
    reducer_available = 4'b1111;
    tick();
    RESET = 1'b0;
    host_if.sum_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (host_if.sum_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d got %b want 0", k, host_if.sum_valid); end
    end
    host_if.sum_ack = 1'b0;
  endtask

`ifdef PATCH_ROW_DISPATCHER_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    reducer_available     = 4'b1111;
    host_if.cfg_valid     = 1'b1;
    host_if.cfg_patch_num = 10'd50;
    tick();
    checks++; if (init !== 4'b0001) begin errors++; $display("FAIL wd_init got %b want 0001", init); end
    reducer_available = 4'b1110;
    host_if.cfg_valid = 1'b0;
    for (int k = 1; k <= 15; k++) tick();
    checks++; if (wd_err !== 4'b0000) begin errors++; $display("FAIL wd_early got %b want 0000", wd_err); end
    tick();
    checks++; if (wd_err !== 4'b0001) begin errors++; $display("FAIL wd_fire got %b want 0001", wd_err); end
    reducer_available = 4'b0001;
    host_if.cfg_valid = 1'b1;
    #1;
    checks++; if (host_if.cfg_ack !== 1'b0) begin errors++; $display("FAIL wd_excluded_ack got %b want 0", host_if.cfg_ack); end
    tick();
    checks++; if (init !== 4'b0000) begin errors++; $display("FAIL wd_excluded_init got %b want 0000", init); end
    host_if.cfg_valid = 1'b0;
  endtask
`endif

  initial begin
    RESET = 1'b1;
    clear_inputs();
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_dual_done();
    test_double_done();
    test_reset_midop();
`ifdef PATCH_ROW_DISPATCHER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
